// File: rtl/escape_seq_parser_pkg.sv
// Shared types for the VT100/ANSI escape-sequence parser: command codes, CSI
// parameter bundle, ASCII control constants and parser states.
package escape_seq_parser_pkg;

   localparam int unsigned MAX_PN   = 2;
   localparam int unsigned PN_SAT   = 255;
   localparam int unsigned PN_IDX_W = $clog2(MAX_PN + 1);

   typedef enum logic [4:0] {
      NONE,
      CR,
      LF,
      BS,
      HT,
      IND,
      RI,
      NEL,
      DECSC,
      DECRC,
      RIS,
      CUU,
      CUD,
      CUF,
      CUB,
      CUP,
      ED,
      EL,
      SGR,
      DECSTBM,
      SM,
      RM,
      DECSET,
      DECRST
   } CommandsType;

   // pn[0] is Pn1, pn[1] is Pn2
   typedef struct packed {
      logic [MAX_PN-1:0][7:0] pn;
   } Param_t;

   localparam logic [7:0] ASCII_ESC = 8'h1B;
   localparam logic [7:0] ASCII_CAN = 8'h18;
   localparam logic [7:0] ASCII_SUB = 8'h1A;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_BS  = 8'h08;
   localparam logic [7:0] ASCII_HT  = 8'h09;

   typedef enum logic [2:0] {
      ST_GROUND,
      ST_ESC,
      ST_CSI,
      ST_CSI_PRIV,
      ST_CSI_IGNORE,
      ST_EMIT
   } parser_state_t;

   // Decimal accumulate with saturation; the product is formed at 12 bits
   // (255*10+9 = 2559) before clamping to the 8-bit field.
   function automatic logic [7:0] acc_step(input logic [7:0] acc, input logic [3:0] digit);
      logic [11:0] w_sum;
      w_sum = 12'(acc) * 12'd10 + 12'(digit);
      return (w_sum > 12'(PN_SAT)) ? 8'(PN_SAT) : w_sum[7:0];
   endfunction

endpackage

// File: rtl/escape_seq_parser_csi_final_decoder.sv
// Combinational decode of a CSI final byte (plus private-marker flag) into a
// command code; o_hit is low for finals the consumers do not implement.
module csi_final_decoder
   import escape_seq_parser_pkg::*;
(
   input  logic        i_private,
   input  logic [7:0]  i_final,
   output CommandsType o_cmd,
   output logic        o_hit
);

   always_comb begin
      o_cmd = NONE;
      o_hit = 1'b0;
      if (i_private) begin
         case (i_final)
            8'h68:   begin o_cmd = DECSET; o_hit = 1'b1; end
            8'h6C:   begin o_cmd = DECRST; o_hit = 1'b1; end
            default: begin o_cmd = NONE;   o_hit = 1'b0; end
         endcase
      end else begin
         o_hit = 1'b1;
         case (i_final)
            8'h41:   o_cmd = CUU;
            8'h42:   o_cmd = CUD;
            8'h43:   o_cmd = CUF;
            8'h44:   o_cmd = CUB;
            8'h48:   o_cmd = CUP;
            8'h66:   o_cmd = CUP;
            8'h4A:   o_cmd = ED;
            8'h4B:   o_cmd = EL;
            8'h6D:   o_cmd = SGR;
            8'h72:   o_cmd = DECSTBM;
            8'h68:   o_cmd = SM;
            8'h6C:   o_cmd = RM;
            default: begin o_cmd = NONE; o_hit = 1'b0; end
         endcase
      end
   end

endmodule

// File: rtl/escape_seq_parser.sv
// Byte-level VT100/ANSI escape-sequence parser: splits the receive stream into
// printable characters and decoded commands with up to MAX_PN decimal params.
module escape_seq_parser
   import escape_seq_parser_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        charReady,
   output logic [7:0]  charData,
   output logic        commandReady,
   output CommandsType commandType,
   output Param_t      param
);

   parser_state_t         r_state;
   logic                  r_in_ready;
   logic                  r_char_ready;
   logic [7:0]            r_char_data;
   logic                  r_cmd_ready;
   CommandsType           r_cmd_type;
   Param_t                r_param;
   logic [7:0]            r_acc;
   logic [PN_IDX_W-1:0]   r_pn_idx;
   Param_t                r_pn;
   logic                  r_first;

   logic        w_accept;
   logic        w_is_digit;
   logic        w_is_final;
   logic        w_is_inter;
   logic        w_is_privmark;
   logic        w_is_print;
   logic        w_is_abort;
   logic        w_exec_hit;
   CommandsType w_exec_cmd;
   logic        w_private;
   CommandsType w_dec_cmd;
   logic        w_dec_hit;
   Param_t      w_pn_final;

   assign w_accept      = in_valid & r_in_ready;
   assign w_is_digit    = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign w_is_final    = (in_data >= 8'h40) && (in_data <= 8'h7E);
   assign w_is_inter    = (in_data >= 8'h20) && (in_data <= 8'h2F);
   assign w_is_privmark = (in_data == 8'h3A) || ((in_data >= 8'h3C) && (in_data <= 8'h3F));
   assign w_is_print    = (in_data >= 8'h20) && (in_data <= 8'h7E);
   assign w_is_abort    = (in_data == ASCII_CAN) || (in_data == ASCII_SUB);
   assign w_private     = (r_state == ST_CSI_PRIV);

   always_comb begin
      w_exec_hit = 1'b1;
      case (in_data)
         ASCII_CR: w_exec_cmd = CR;
         ASCII_LF: w_exec_cmd = LF;
         ASCII_BS: w_exec_cmd = BS;
         ASCII_HT: w_exec_cmd = HT;
         default:  begin w_exec_cmd = NONE; w_exec_hit = 1'b0; end
      endcase
   end

   // Parameter set with the running accumulator folded into the current slot;
   // used both when ';' closes a field and when the final byte ends the sequence.
   always_comb begin
      w_pn_final = r_pn;
      for (int unsigned i = 0; i < MAX_PN; i++) begin
         if (r_pn_idx == PN_IDX_W'(i)) w_pn_final.pn[i] = r_acc;
      end
   end

   csi_final_decoder u_csi_final_decoder (
      .i_private (w_private),
      .i_final   (in_data),
      .o_cmd     (w_dec_cmd),
      .o_hit     (w_dec_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_GROUND;
         r_in_ready   <= 1'b1;
         r_char_ready <= 1'b0;
         r_char_data  <= '0;
         r_cmd_ready  <= 1'b0;
         r_cmd_type   <= NONE;
         r_param      <= '0;
         r_acc        <= '0;
         r_pn_idx     <= '0;
         r_pn         <= '0;
         r_first      <= 1'b0;
      end else begin
         r_char_ready <= 1'b0;
         r_cmd_ready  <= 1'b0;
         if (r_state == ST_EMIT) begin
            r_state    <= ST_GROUND;
            r_in_ready <= 1'b1;
         end else if (w_accept) begin
            case (r_state)
               ST_GROUND: begin
                  if (in_data == ASCII_ESC) begin
                     r_state <= ST_ESC;
                  end else if (w_is_print) begin
                     r_char_ready <= 1'b1;
                     r_char_data  <= in_data;
                  end else if (w_exec_hit) begin
                     r_cmd_ready <= 1'b1;
                     r_cmd_type  <= w_exec_cmd;
                     r_param     <= '0;
                  end
               end
               ST_ESC: begin
                  case (in_data)
                     8'h5B: begin
                        r_state  <= ST_CSI;
                        r_acc    <= '0;
                        r_pn_idx <= '0;
                        r_pn     <= '0;
                        r_first  <= 1'b1;
                     end
                     ASCII_ESC: r_state <= ST_ESC;
                     8'h44, 8'h4D, 8'h45, 8'h37, 8'h38, 8'h63: begin
                        r_state     <= ST_EMIT;
                        r_in_ready  <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_param     <= '0;
                        case (in_data)
                           8'h44:   r_cmd_type <= IND;
                           8'h4D:   r_cmd_type <= RI;
                           8'h45:   r_cmd_type <= NEL;
                           8'h37:   r_cmd_type <= DECSC;
                           8'h38:   r_cmd_type <= DECRC;
                           default: r_cmd_type <= RIS;
                        endcase
                     end
                     default: r_state <= ST_GROUND;
                  endcase
               end
               ST_CSI, ST_CSI_PRIV, ST_CSI_IGNORE: begin
                  if (w_is_abort) begin
                     r_state <= ST_GROUND;
                  end else if (in_data == ASCII_ESC) begin
                     r_state <= ST_ESC;
                  end else if (w_exec_hit && (in_data != ASCII_HT)) begin
                     r_cmd_ready <= 1'b1;
                     r_cmd_type  <= w_exec_cmd;
                     r_param     <= '0;
                  end else if (r_state == ST_CSI_IGNORE) begin
                     if (w_is_final) r_state <= ST_GROUND;
                  end else if (w_is_digit) begin
                     r_acc   <= acc_step(r_acc, in_data[3:0]);
                     r_first <= 1'b0;
                  end else if (in_data == 8'h3B) begin
                     r_pn    <= w_pn_final;
                     r_acc   <= '0;
                     r_first <= 1'b0;
                     if (r_pn_idx < PN_IDX_W'(MAX_PN)) r_pn_idx <= r_pn_idx + 1'b1;
                  end else if ((in_data == 8'h3F) && r_first && (r_state == ST_CSI)) begin
                     r_state <= ST_CSI_PRIV;
                     r_first <= 1'b0;
                  end else if (w_is_inter || w_is_privmark) begin
                     r_state <= ST_CSI_IGNORE;
                  end else if (w_is_final) begin
                     if (w_dec_hit) begin
                        r_state     <= ST_EMIT;
                        r_in_ready  <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_cmd_type  <= w_dec_cmd;
                        r_param     <= w_pn_final;
                     end else begin
                        r_state <= ST_GROUND;
                     end
                  end
               end
               default: r_state <= ST_GROUND;
            endcase
         end
      end
   end

   assign in_ready     = r_in_ready;
   assign charReady    = r_char_ready;
   assign charData     = r_char_data;
   assign commandReady = r_cmd_ready;
   assign commandType  = r_cmd_type;
   assign param        = r_param;

endmodule

// File: tb/tb_escape_seq_parser.sv
// Directed self-checking bench for escape_seq_parser.
module tb_escape_seq_parser;
   import escape_seq_parser_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        charReady;
   logic [7:0]  charData;
   logic        commandReady;
   CommandsType commandType;
   Param_t      param;

   int total;
   int bad;

   int          cmd_cnt;
   int          char_cnt;
   int          both_cnt;
   CommandsType last_cmd;
   Param_t      last_param;
   logic [7:0]  last_char;

   escape_seq_parser dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .charReady    (charReady),
      .charData     (charData),
      .commandReady (commandReady),
      .commandType  (commandType),
      .param        (param)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cmd_cnt  = 0;
      char_cnt = 0;
      both_cnt = 0;
      last_cmd   = NONE;
      last_param = '0;
      last_char  = 8'h00;
   end

   always @(negedge clk) begin
      if (rst) begin
         if (commandReady) begin
            cmd_cnt    = cmd_cnt + 1;
            last_cmd   = commandType;
            last_param = param;
         end
         if (charReady) begin
            char_cnt  = char_cnt + 1;
            last_char = charData;
         end
         if (charReady && commandReady) both_cnt = both_cnt + 1;
      end
   end

   // Called at a negedge; returns at the negedge right after the accepting posedge.
   task automatic send_byte(input logic [7:0] b);
      int unsigned n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) begin
         total++; bad++;
         $display("FAIL in_ready_timeout: byte=%02h in_ready=%b required 1", b, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic send_esc(input string s);
      send_byte(ASCII_ESC);
      send_str(s);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_cmd(input string name, input int base, input int exp_n,
                            input CommandsType exp_cmd, input logic [7:0] p1, input logic [7:0] p2);
      total++;
      if ((cmd_cnt - base) !== exp_n) begin
         bad++;
         $display("FAIL %s_count: got %0d required %0d", name, cmd_cnt - base, exp_n);
      end
      total++;
      if (last_cmd !== exp_cmd) begin
         bad++;
         $display("FAIL %s_type: got %0d required %0d", name, last_cmd, exp_cmd);
      end
      total++;
      if (last_param.pn[0] !== p1 || last_param.pn[1] !== p2) begin
         bad++;
         $display("FAIL %s_param: got %0d,%0d required %0d,%0d", name,
                  last_param.pn[0], last_param.pn[1], p1, p2);
      end
   endtask

   task automatic test_reset();
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      total++;
      if (charReady !== 1'b0) begin bad++; $display("FAIL reset_charReady: got %b required 0", charReady); end
      total++;
      if (commandReady !== 1'b0) begin bad++; $display("FAIL reset_commandReady: got %b required 0", commandReady); end
      total++;
      if (charData !== 8'h00) begin bad++; $display("FAIL reset_charData: got %02h required 00", charData); end
      total++;
      if (commandType !== NONE) begin bad++; $display("FAIL reset_commandType: got %0d required %0d", commandType, NONE); end
      total++;
      if (param !== 16'h0000) begin bad++; $display("FAIL reset_param: got %04h required 0000", param); end
   endtask

   task automatic test_decstbm();
      int cb, hb;
      cb = cmd_cnt; hb = char_cnt;
      send_esc("[3;20");
      send_byte(8'h72);
      total++;
      if (commandReady !== 1'b1) begin bad++; $display("FAIL decstbm_pulse: got %b required 1", commandReady); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL decstbm_stall: got %b required 0", in_ready); end
      total++;
      if (commandType !== DECSTBM || param.pn[0] !== 8'd3 || param.pn[1] !== 8'd20) begin
         bad++;
         $display("FAIL decstbm_out: got %0d %0d,%0d required %0d 3,20", commandType, param.pn[0], param.pn[1], DECSTBM);
      end
      idle(1);
      total++;
      if (commandReady !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL decstbm_after: got cr=%b rdy=%b required 0 1", commandReady, in_ready);
      end
      idle(2);
      check_cmd("decstbm", cb, 1, DECSTBM, 8'd3, 8'd20);
      total++;
      if ((char_cnt - hb) !== 0) begin bad++; $display("FAIL decstbm_chars: got %0d required 0", char_cnt - hb); end
   endtask

   task automatic test_defaults();
      int cb;
      cb = cmd_cnt;
      send_esc("[r");
      idle(2);
      check_cmd("default_r", cb, 1, DECSTBM, 8'd0, 8'd0);
      cb = cmd_cnt;
      send_esc("[;5H");
      idle(2);
      check_cmd("cup_omit", cb, 1, CUP, 8'd0, 8'd5);
   endtask

   task automatic test_saturation();
      int cb;
      cb = cmd_cnt;
      send_esc("[999A");
      idle(2);
      check_cmd("sat", cb, 1, CUU, 8'd255, 8'd0);
   endtask

   task automatic test_extra_params();
      int cb;
      cb = cmd_cnt;
      send_esc("[1;2;3;4m");
      idle(2);
      check_cmd("extra", cb, 1, SGR, 8'd1, 8'd2);
   endtask

   task automatic test_private();
      int cb;
      cb = cmd_cnt;
      send_esc("[?25l");
      idle(2);
      check_cmd("decrst", cb, 1, DECRST, 8'd25, 8'd0);
      cb = cmd_cnt;
      send_esc("[?1h");
      idle(2);
      check_cmd("decset", cb, 1, DECSET, 8'd1, 8'd0);
   endtask

   task automatic test_can_abort();
      int cb, hb;
      cb = cmd_cnt; hb = char_cnt;
      send_esc("[12");
      send_byte(ASCII_CAN);
      send_str("A");
      idle(2);
      total++;
      if ((cmd_cnt - cb) !== 0) begin bad++; $display("FAIL can_cmds: got %0d required 0", cmd_cnt - cb); end
      total++;
      if ((char_cnt - hb) !== 1 || last_char !== 8'h41) begin
         bad++;
         $display("FAIL can_char: got n=%0d c=%02h required n=1 c=41", char_cnt - hb, last_char);
      end
   endtask

   task automatic test_esc_restart();
      int cb;
      cb = cmd_cnt;
      send_esc("[5");
      send_esc("[7B");
      idle(2);
      check_cmd("restart", cb, 1, CUD, 8'd7, 8'd0);
   endtask

   task automatic test_unknown_final();
      int cb, hb;
      cb = cmd_cnt; hb = char_cnt;
      send_esc("[5z");
      send_str("x");
      send_esc("[1!p");
      idle(2);
      total++;
      if ((cmd_cnt - cb) !== 0) begin bad++; $display("FAIL unknown_cmds: got %0d required 0", cmd_cnt - cb); end
      total++;
      if ((char_cnt - hb) !== 1 || last_char !== 8'h78) begin
         bad++;
         $display("FAIL unknown_char: got n=%0d c=%02h required n=1 c=78", char_cnt - hb, last_char);
      end
   endtask

   task automatic test_esc_commands();
      int cb;
      cb = cmd_cnt;
      send_esc("D");
      idle(2);
      check_cmd("ind", cb, 1, IND, 8'd0, 8'd0);
      cb = cmd_cnt;
      send_esc("7");
      idle(2);
      check_cmd("decsc", cb, 1, DECSC, 8'd0, 8'd0);
      cb = cmd_cnt;
      send_esc("c");
      idle(2);
      check_cmd("ris", cb, 1, RIS, 8'd0, 8'd0);
   endtask

   task automatic test_exec_in_csi();
      int cb;
      cb = cmd_cnt;
      send_byte(ASCII_LF);
      idle(1);
      check_cmd("lf", cb, 1, LF, 8'd0, 8'd0);
      cb = cmd_cnt;
      send_esc("[3");
      send_byte(ASCII_CR);
      total++;
      if (commandReady !== 1'b1 || commandType !== CR) begin
         bad++;
         $display("FAIL csi_cr: got cr=%b t=%0d required 1 %0d", commandReady, commandType, CR);
      end
      send_str("4C");
      idle(2);
      check_cmd("csi_exec", cb, 2, CUF, 8'd34, 8'd0);
   endtask

   task automatic test_back_to_back();
      int cb, hb;
      cb = cmd_cnt; hb = char_cnt;
      send_str("Hi");
      send_byte(8'h01);
      send_byte(8'h7F);
      send_esc("M");
      send_str("Z");
      idle(2);
      total++;
      if ((char_cnt - hb) !== 3 || last_char !== 8'h5A) begin
         bad++;
         $display("FAIL b2b_chars: got n=%0d c=%02h required n=3 c=5A", char_cnt - hb, last_char);
      end
      total++;
      if ((cmd_cnt - cb) !== 1 || last_cmd !== RI) begin
         bad++;
         $display("FAIL b2b_cmd: got n=%0d t=%0d required n=1 t=%0d", cmd_cnt - cb, last_cmd, RI);
      end
      total++;
      if (both_cnt !== 0) begin bad++; $display("FAIL exclusive: got %0d required 0", both_cnt); end
   endtask

   task automatic test_reset_mid();
      int cb, hb;
      send_esc("[4");
      rst = 1'b0;
      #1;
      test_reset();
      idle(2);
      rst = 1'b1;
      idle(1);
      cb = cmd_cnt; hb = char_cnt;
      send_str("B");
      idle(2);
      total++;
      if ((cmd_cnt - cb) !== 0) begin bad++; $display("FAIL rstmid_cmds: got %0d required 0", cmd_cnt - cb); end
      total++;
      if ((char_cnt - hb) !== 1 || last_char !== 8'h42) begin
         bad++;
         $display("FAIL rstmid_char: got n=%0d c=%02h required n=1 c=42", char_cnt - hb, last_char);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      idle(2);
      test_reset();
      rst = 1'b1;
      idle(1);
      test_decstbm();
      test_defaults();
      test_saturation();
      test_extra_params();
      test_private();
      test_can_abort();
      test_esc_restart();
      test_unknown_final();
      test_esc_commands();
      test_exec_in_csi();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
